i2c_reg_slave: RTL and testbench

I2C target (responder) that exposes a small byte-addressable register file to an I2C controller. It oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, matches its 7-bit address, and handles multi-byte register writes and reads with an auto-incrementing pointer. Host logic reads and writes the same register file through a parallel port. It sits on the I2C bus beside I2C_MASTER/I2C_SLAVE, driving SDA open-drain.

---
 rtl/i2c_reg_slave_if.sv | 25 ++
 rtl/i2c_reg_slave.sv | 159 +++++++++++++++
 tb/tb_i2c_reg_slave.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_slave_if.sv
// rtl/i2c_reg_slave_if.sv - host-side register port and status bundle of the I2C register target
interface i2c_reg_slave_if #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
);
    logic [6:0]    s_addr;
    logic [PW-1:0] host_addr;
    logic          host_we;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          wr_strobe;
    logic [PW-1:0] wr_index;
    logic [7:0]    wr_byte;
    logic          busy;

    modport slave (
        input  s_addr, host_addr, host_we, host_wdata,
        output host_rdata, wr_strobe, wr_index, wr_byte, busy
    );

    modport master (
        output s_addr, host_addr, host_we, host_wdata,
        input  host_rdata, wr_strobe, wr_index, wr_byte, busy
    );
endinterface

// File: rtl/i2c_reg_slave.sv
// rtl/i2c_reg_slave.sv - oversampled I2C target exposing an auto-incrementing byte register file
module i2c_reg_slave #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    i2c_reg_slave_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    scl_q, sda_q;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg, tx;
    logic [PW-1:0] ptr;
    logic          sda_oe, rd_acked, busy_r;
    logic          wr_strobe_r;
    logic [PW-1:0] wr_index_r;
    logic [7:0]    wr_byte_r;
    logic [7:0]    regs [DEPTH];

    // [0],[1] synchronize, [2] holds the previous synchronized level for edge detection
    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start_ev = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_ev  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

    logic [7:0] rx_byte;
    logic       byte_done, rx_state, addr_match, wr_en, ptr_ld, rd_load;
    assign rx_byte    = {shreg[6:0], sda_q[1]};
    assign byte_done  = (bit_cnt == 4'd8);
    assign rx_state   = (state == S_ADDR) || (state == S_PTR) || (state == S_WR_DATA);
    assign addr_match = (shreg[7:1] == bus.s_addr);
    assign wr_en      = (state == S_WR_DATA) && scl_rise && (bit_cnt == 4'd7);
    assign ptr_ld     = (state == S_PTR) && scl_rise && (bit_cnt == 4'd7);
    assign rd_load    = scl_fall && (((state == S_ADDR_ACK) && shreg[0]) ||
                                     ((state == S_RD_ACK) && rd_acked));

    assign sda            = sda_oe ? 1'b0 : 1'bz;
    assign bus.host_rdata = regs[bus.host_addr];
    assign bus.wr_strobe  = wr_strobe_r;
    assign bus.wr_index   = wr_index_r;
    assign bus.wr_byte    = wr_byte_r;
    assign bus.busy       = busy_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_ADDR:     if (scl_fall && byte_done) state_n = addr_match ? S_ADDR_ACK : S_IGNORE;
            S_ADDR_ACK: if (scl_fall) state_n = shreg[0] ? S_RD_DATA : S_PTR;
            S_PTR:      if (scl_fall && byte_done) state_n = S_PTR_ACK;
            S_PTR_ACK:  if (scl_fall) state_n = S_WR_DATA;
            S_WR_DATA:  if (scl_fall && byte_done) state_n = S_WR_ACK;
            S_WR_ACK:   if (scl_fall) state_n = S_WR_DATA;
            S_RD_DATA:  if (scl_fall && byte_done) state_n = S_RD_ACK;
            S_RD_ACK: begin
                if (scl_rise && sda_q[1])      state_n = S_IGNORE;
                else if (scl_fall && rd_acked) state_n = S_RD_DATA;
            end
            default: ;
        endcase
        if (start_ev)     state_n = S_ADDR;
        else if (stop_ev) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q       <= 3'b111;
            sda_q       <= 3'b111;
            bit_cnt     <= 4'd0;
            shreg       <= 8'h00;
            tx          <= 8'h00;
            ptr         <= '0;
            sda_oe      <= 1'b0;
            rd_acked    <= 1'b0;
            busy_r      <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_index_r  <= '0;
            wr_byte_r   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            scl_q       <= {scl_q[1:0], scl};
            sda_q       <= {sda_q[1:0], sda};
            wr_strobe_r <= 1'b0;
            // host write first so a same-cycle I2C write to the same register overrides it
            if (bus.host_we) regs[bus.host_addr] <= bus.host_wdata;
            if (start_ev || stop_ev) begin
                bit_cnt  <= 4'd0;
                sda_oe   <= 1'b0;
                busy_r   <= 1'b0;
                rd_acked <= 1'b0;
            end else begin
                if (rx_state && scl_rise && !byte_done) begin
                    shreg   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if ((state == S_RD_DATA) && scl_rise && !byte_done) bit_cnt <= bit_cnt + 4'd1;
                if (wr_en) begin
                    regs[ptr]   <= rx_byte;
                    wr_strobe_r <= 1'b1;
                    wr_index_r  <= ptr;
                    wr_byte_r   <= rx_byte;
                    ptr         <= ptr + 1'b1;
                end
                if (ptr_ld) ptr <= rx_byte[PW-1:0];
                if (scl_fall) begin
                    case (state)
                        S_ADDR: if (byte_done) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= addr_match;
                            busy_r  <= addr_match;
                        end
                        S_PTR, S_WR_DATA: if (byte_done) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b1;
                        end
                        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: sda_oe <= 1'b0;
                        S_RD_DATA: begin
                            if (byte_done) begin
                                bit_cnt  <= 4'd0;
                                sda_oe   <= 1'b0;
                                rd_acked <= 1'b0;
                            end else begin
                                sda_oe <= ~tx[7];
                                tx     <= {tx[6:0], 1'b0};
                            end
                        end
                        default: ;
                    endcase
                end
                // MSB goes out on the same falling edge that ends the preceding ACK slot
                if (rd_load) begin
                    tx     <= {regs[ptr][6:0], 1'b0};
                    sda_oe <= ~regs[ptr][7];
                end
                if ((state == S_RD_ACK) && scl_rise) begin
                    if (!sda_q[1]) begin
                        ptr      <= ptr + 1'b1;
                        rd_acked <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb/tb_i2c_reg_slave.sv - directed self-checking bench for i2c_reg_slave
module tb_i2c_reg_slave;
    localparam int DEPTH = 16;
    localparam int PW    = 4;
    localparam int Q     = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;
    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_reg_slave_if #(.DEPTH(DEPTH)) bus ();

    i2c_reg_slave #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int dut_low = 0;
    logic busy_seen = 1'b0;
    logic [PW-1:0] sq_idx [$];
    logic [7:0]    sq_byte [$];

    always @(negedge clk) begin
        if (!sda_low && sda === 1'b0) dut_low++;
        if (bus.busy) busy_seen = 1'b1;
        if (bus.wr_strobe) begin
            sq_idx.push_back(bus.wr_index);
            sq_byte.push_back(bus.wr_byte);
        end
    end

    task automatic pulse(output logic smp);
        #Q scl = 1'b1;
        #Q smp = sda;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start;
        sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop;
        sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q sda_low = 1'b0;
        #Q;
    endtask

    // col: pulse host_we in the exact CLK where the 8th-bit write lands (pin edge + 3 CLK)
    task automatic send_byte(input logic [7:0] b, input logic col, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i];
            if (i == 0 && col) begin
                #Q scl = 1'b1;
                #20 bus.host_we = 1'b1;
                #10 bus.host_we = 1'b0;
                #20 scl = 1'b0;
                #Q;
            end else begin
                pulse(s);
            end
        end
        sda_low = 1'b0;
        pulse(ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            pulse(s);
            d[i] = s;
        end
        sda_low = ~nack;
        pulse(s);
        sda_low = 1'b0;
    endtask

    task automatic host_write(input logic [PW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        @(negedge clk);
        bus.host_we    = 1'b0;
    endtask

    task automatic test_reset;
        int bad;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (sda !== 1'b1 || bus.busy !== 1'b0 || bus.wr_strobe !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: sda=%b busy=%b strobe=%b expected 1 0 0", sda, bus.busy, bus.wr_strobe);
        end
        tests++;
        if (bus.wr_index !== 4'd0 || bus.wr_byte !== 8'h00) begin
            fails++;
            $display("FAIL reset_wr_bus: index=%h byte=%h expected 0 00", bus.wr_index, bus.wr_byte);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.host_addr = PW'(i);
            #1;
            if (bus.host_rdata !== 8'h00) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_regs: %0d nonzero registers expected 0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_write;
        logic a0, a1, a2, a3;
        sq_idx.delete(); sq_byte.delete();
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h03, 1'b0, a1);
        send_byte(8'hAC, 1'b0, a2);
        send_byte(8'h47, 1'b0, a3);
        i2c_stop;
        @(negedge clk);
        tests++;
        if ({a0, a1, a2, a3} !== 4'b0000) begin
            fails++;
            $display("FAIL write_acks: got %b expected 0000", {a0, a1, a2, a3});
        end
        tests++;
        if (sq_idx.size() != 2 || sq_idx[0] !== 4'd3 || sq_byte[0] !== 8'hAC ||
            sq_idx[1] !== 4'd4 || sq_byte[1] !== 8'h47) begin
            fails++;
            $display("FAIL write_strobes: count=%0d expected 2 strobes (3,ac) (4,47)", sq_idx.size());
        end
        bus.host_addr = 4'd4;
        #1;
        tests++;
        if (bus.host_rdata !== 8'h47) begin
            fails++;
            $display("FAIL write_reg4: got %h expected 47", bus.host_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_read;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        host_write(4'd5, 8'h28);
        host_write(4'd6, 8'hFB);
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h05, 1'b0, a1);
        i2c_start;
        send_byte(8'hBD, 1'b0, a2);
        tests++;
        if (bus.busy !== 1'b1 || {a0, a1, a2} !== 3'b000) begin
            fails++;
            $display("FAIL read_addr: busy=%b acks=%b expected 1 000", bus.busy, {a0, a1, a2});
        end
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        tests++;
        if (d0 !== 8'h28 || d1 !== 8'hFB) begin
            fails++;
            $display("FAIL read_data: got %h %h expected 28 fb", d0, d1);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL read_busy_after_nack: got %b expected 0", bus.busy);
        end
        i2c_stop;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3;
        logic [7:0] d;
        host_write(4'd1, 8'h3C);
        sq_idx.delete(); sq_byte.delete();
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h0F, 1'b0, a1);
        send_byte(8'h11, 1'b0, a2);
        send_byte(8'h22, 1'b0, a3);
        i2c_stop;
        @(negedge clk);
        bus.host_addr = 4'd15;
        #1;
        tests++;
        if (bus.host_rdata !== 8'h11) begin
            fails++;
            $display("FAIL wrap_reg15: got %h expected 11", bus.host_rdata);
        end
        bus.host_addr = 4'd0;
        #1;
        tests++;
        if (bus.host_rdata !== 8'h22 || sq_idx.size() != 2 || sq_idx[1] !== 4'd0) begin
            fails++;
            $display("FAIL wrap_reg0: got %h strobes=%0d expected 22 2", bus.host_rdata, sq_idx.size());
        end
        @(negedge clk);
        i2c_start;
        send_byte(8'hBD, 1'b0, a0);
        recv_byte(1'b1, d);
        i2c_stop;
        tests++;
        if (d !== 8'h3C) begin
            fails++;
            $display("FAIL wrap_ptr_read: got %h expected 3c (reg1)", d);
        end
        @(negedge clk);
    endtask

    task automatic test_mismatch;
        logic a0, a1;
        int low0;
        low0 = dut_low;
        busy_seen = 1'b0;
        sq_idx.delete(); sq_byte.delete();
        i2c_start;
        send_byte(8'hA0, 1'b0, a0);
        send_byte(8'h55, 1'b0, a1);
        i2c_stop;
        @(negedge clk);
        tests++;
        if (a0 !== 1'b1 || dut_low != low0) begin
            fails++;
            $display("FAIL mismatch_sda: ack=%b dut_low_cycles=%0d expected 1 0", a0, dut_low - low0);
        end
        tests++;
        if (busy_seen !== 1'b0 || sq_idx.size() != 0) begin
            fails++;
            $display("FAIL mismatch_side_effects: busy_seen=%b strobes=%0d expected 0 0", busy_seen, sq_idx.size());
        end
    endtask

    task automatic test_abort;
        logic a0, a1, s;
        sq_idx.delete(); sq_byte.delete();
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h08, 1'b0, a1);
        for (int i = 0; i < 4; i++) begin
            sda_low = 1'b0;
            pulse(s);
        end
        i2c_stop;
        repeat (4) @(negedge clk);
        bus.host_addr = 4'd8;
        #1;
        tests++;
        if (sq_idx.size() != 0 || bus.host_rdata !== 8'h00) begin
            fails++;
            $display("FAIL abort_no_write: strobes=%0d reg8=%h expected 0 00", sq_idx.size(), bus.host_rdata);
        end
        tests++;
        if (sda !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_release: sda=%b busy=%b expected 1 0", sda, bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_collision;
        logic a0, a1, a2;
        bus.host_addr  = 4'd2;
        bus.host_wdata = 8'h55;
        @(negedge clk);
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h02, 1'b0, a1);
        send_byte(8'h99, 1'b1, a2);
        i2c_stop;
        @(negedge clk);
        #1;
        tests++;
        if (bus.host_rdata !== 8'h99) begin
            fails++;
            $display("FAIL collision_same_reg: reg2=%h expected 99", bus.host_rdata);
        end
        bus.host_addr  = 4'd7;
        bus.host_wdata = 8'h66;
        @(negedge clk);
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h03, 1'b0, a1);
        send_byte(8'h5A, 1'b1, a2);
        i2c_stop;
        @(negedge clk);
        #1;
        tests++;
        if (bus.host_rdata !== 8'h66) begin
            fails++;
            $display("FAIL collision_host_other: reg7=%h expected 66", bus.host_rdata);
        end
        bus.host_addr = 4'd3;
        #1;
        tests++;
        if (bus.host_rdata !== 8'h5A) begin
            fails++;
            $display("FAIL collision_i2c_other: reg3=%h expected 5a", bus.host_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic a0, a1, a2;
        int bad, low0;
        i2c_start;
        send_byte(8'hBC, 1'b0, a0);
        send_byte(8'h05, 1'b0, a1);
        i2c_start;
        send_byte(8'hBD, 1'b0, a2);
        tests++;
        if (sda !== 1'b0) begin
            fails++;
            $display("FAIL midreset_driving: sda=%b expected 0 (msb of 28)", sda);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        tests++;
        if (sda !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_release: sda=%b busy=%b expected 1 0", sda, bus.busy);
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.host_addr = PW'(i);
            #1;
            if (bus.host_rdata !== 8'h00) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midreset_regs: %0d nonzero registers expected 0", bad);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        low0 = dut_low;
        busy_seen = 1'b0;
        send_byte(8'hBC, 1'b0, a0);
        i2c_stop;
        @(negedge clk);
        tests++;
        if (a0 !== 1'b1 || dut_low != low0 || busy_seen !== 1'b0) begin
            fails++;
            $display("FAIL midreset_ignore_partial: ack=%b dut_low=%0d busy_seen=%b expected 1 0 0",
                     a0, dut_low - low0, busy_seen);
        end
    endtask

    initial begin
        bus.s_addr     = 7'h5E;
        bus.host_addr  = '0;
        bus.host_we    = 1'b0;
        bus.host_wdata = 8'h00;
        test_reset;
        test_write;
        test_read;
        test_wrap;
        test_mismatch;
        test_abort;
        test_collision;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
